minterm_scanner: RTL and testbench

Sequential truth-table reader for a 4-input single-output combinational function block. On START it drives all 16 input vectors onto the function under test in order 0..15. After a programmable settle time it samples the function output for each vector, assembling the minterm mask and the minterm count. At the end it compares the mask against a parameterised expected minterm list, so a realized function, e.g. MIN(0,2,4,6,9,10,13,15), can be checked in-system.

---
 rtl/minterm_scanner.sv | 117 +++++++++++
 tb/tb_minterm_scanner.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/minterm_scanner.sv
// Truth-table reader for a 4-input, 1-output function block: steps PROBE through
// 0..15, samples SENSE after a settle delay, builds the minterm mask/count and checks it.
module minterm_scanner #(
    parameter int unsigned SETTLE   = 1,
    parameter logic [15:0] EXPECTED = 16'hA655
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        start_i,
    input  logic        sense_i,
    output logic [3:0]  probe_o,
    output logic        busy_o,
    output logic        done_o,
    output logic [15:0] mask_o,
    output logic [4:0]  count_o,
    output logic        match_o
);

    localparam logic [3:0] SETTLE_LD = 4'(SETTLE);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_SAMPLE,
        ST_FIN
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  probe_q, probe_d;
    logic [3:0]  settle_q, settle_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [15:0] mask_q, mask_d;
    logic [4:0]  count_q, count_d;
    logic        match_q, match_d;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q  <= ST_IDLE;
            probe_q  <= 4'd0;
            settle_q <= 4'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            mask_q   <= 16'd0;
            count_q  <= 5'd0;
            match_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            probe_q  <= probe_d;
            settle_q <= settle_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            mask_q   <= mask_d;
            count_q  <= count_d;
            match_q  <= match_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        probe_d  = probe_q;
        settle_d = settle_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        mask_d   = mask_q;
        count_d  = count_q;
        match_d  = match_q;

        unique case (state_q)
            // FIN has BUSY low, so a START there is accepted exactly as in IDLE.
            ST_IDLE, ST_FIN: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                if (start_i) begin
                    mask_d   = 16'd0;
                    count_d  = 5'd0;
                    match_d  = 1'b0;
                    probe_d  = 4'd0;
                    busy_d   = 1'b1;
                    settle_d = SETTLE_LD;
                    state_d  = (SETTLE_LD == 4'd0) ? ST_SAMPLE : ST_WAIT;
                end
            end
            ST_WAIT: begin
                settle_d = settle_q - 4'd1;
                if (settle_q <= 4'd1) begin
                    state_d = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                mask_d[probe_q] = sense_i;
                count_d         = count_q + {4'd0, sense_i};
                if (probe_q != 4'd15) begin
                    probe_d  = probe_q + 4'd1;
                    settle_d = SETTLE_LD;
                    state_d  = (SETTLE_LD == 4'd0) ? ST_SAMPLE : ST_WAIT;
                end else begin
                    // Compare against the mask including the bit captured on this edge.
                    state_d = ST_FIN;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    match_d = (mask_d == EXPECTED);
                    probe_d = 4'd0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign probe_o = probe_q;
    assign busy_o  = busy_q;
    assign done_o  = done_q;
    assign mask_o  = mask_q;
    assign count_o = count_q;
    assign match_o = match_q;

endmodule

// File: tb/tb_minterm_scanner.sv
// Directed bench for minterm_scanner: SETTLE=1 instance (a) and SETTLE=0 instance (b)
// each driven by a combinational model of the function under test.
`timescale 1ns/1ps
module tb_minterm_scanner;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_a = 1'b0, start_b = 1'b0;
    logic        sense_a, sense_b;
    logic [1:0]  mode = 2'd0;  // 0 model, 1 tied 0, 2 tied 1, 3 model with F(13)=0
    logic [3:0]  probe_a, probe_b;
    logic        busy_a, busy_b, done_a, done_b, match_a, match_b;
    logic [15:0] mask_a, mask_b;
    logic [4:0]  count_a, count_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    function automatic logic model_f(input logic [3:0] k, input logic [1:0] m);
        logic a, b, c, d;
        {a, b, c, d} = k;
        case (m)
            2'd1:    return 1'b0;
            2'd2:    return 1'b1;
            2'd3:    return (k == 4'd13) ? 1'b0 :
                            ((!a && !d) || (a && !c && d) || (!b && c && !d) || (a && b && d));
            default: return (!a && !d) || (a && !c && d) || (!b && c && !d) || (a && b && d);
        endcase
    endfunction

    assign sense_a = model_f(probe_a, mode);
    assign sense_b = model_f(probe_b, mode);

    minterm_scanner #(.SETTLE(1), .EXPECTED(16'hA655)) dut_a (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(start_a), .sense_i(sense_a),
        .probe_o(probe_a), .busy_o(busy_a), .done_o(done_a),
        .mask_o(mask_a), .count_o(count_a), .match_o(match_a)
    );

    minterm_scanner #(.SETTLE(0), .EXPECTED(16'hA655)) dut_b (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(start_b), .sense_i(sense_b),
        .probe_o(probe_b), .busy_o(busy_b), .done_o(done_b),
        .mask_o(mask_b), .count_o(count_b), .match_o(match_b)
    );

    // Raise START before an edge; cyc counts edges from the START edge (inclusive)
    // up to the edge after which DONE is seen. Returns #1 into the DONE cycle.
    task automatic launch_a(input bit hold, output int cyc, output bit timed_out);
        @(negedge clk);
        start_a = 1'b1;
        cyc = 0;
        timed_out = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #1;
            cyc++;
            if (!hold) start_a = 1'b0;
            if (done_a) begin
                timed_out = 1'b0;
                break;
            end
        end
        start_a = 1'b0;
        $display("scan a: cycles=%0d mask=%h count=%0d match=%0b busy=%0b",
                 cyc, mask_a, count_a, match_a, busy_a);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({probe_a, busy_a, done_a, mask_a, count_a, match_a} !== 28'd0) begin
            errors++;
            $display("FAIL reset_state: got probe=%h busy=%b done=%b mask=%h count=%0d match=%b, want all zero",
                     probe_a, busy_a, done_a, mask_a, count_a, match_a);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_scan(input string name, input logic [1:0] m,
                             input logic [15:0] exp_mask, input logic [4:0] exp_count,
                             input logic exp_match);
        int cyc;
        bit to;
        mode = m;
        launch_a(1'b0, cyc, to);
        checks++;
        if (to || cyc != 33) begin
            errors++;
            $display("FAIL %s_latency: got %0d (timeout=%0b), want 33", name, cyc, to);
        end
        checks++;
        if (mask_a !== exp_mask || count_a !== exp_count) begin
            errors++;
            $display("FAIL %s_result: got mask=%h count=%0d, want mask=%h count=%0d",
                     name, mask_a, count_a, exp_mask, exp_count);
        end
        checks++;
        if (match_a !== exp_match || busy_a !== 1'b0 || probe_a !== 4'd0) begin
            errors++;
            $display("FAIL %s_fin: got match=%b busy=%b probe=%h, want match=%b busy=0 probe=0",
                     name, match_a, busy_a, probe_a, exp_match);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (mask_a !== exp_mask || count_a !== exp_count || match_a !== exp_match || done_a !== 1'b0) begin
            errors++;
            $display("FAIL %s_hold: got mask=%h count=%0d match=%b done=%b, want mask=%h count=%0d match=%b done=0",
                     name, mask_a, count_a, match_a, done_a, exp_mask, exp_count, exp_match);
        end
    endtask

    task automatic test_mid_scan_reset();
        int cyc;
        bit to;
        mode = 2'd0;
        @(negedge clk);
        start_a = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        to = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (probe_a == 4'd7) begin
                to = 1'b0;
                break;
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if (to || busy_a !== 1'b1) begin
            errors++;
            $display("FAIL midreset_reach7: got probe=%h busy=%b, want probe=7 busy=1", probe_a, busy_a);
        end
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if ({probe_a, busy_a, done_a, mask_a, count_a, match_a} !== 28'd0) begin
            errors++;
            $display("FAIL midreset_zero: got probe=%h busy=%b done=%b mask=%h count=%0d match=%b, want all zero",
                     probe_a, busy_a, done_a, mask_a, count_a, match_a);
        end
        rst_n = 1'b1;
        launch_a(1'b0, cyc, to);
        checks++;
        if (to || mask_a !== 16'hA655 || match_a !== 1'b1) begin
            errors++;
            $display("FAIL midreset_rescan: got mask=%h match=%b timeout=%0b, want mask=a655 match=1",
                     mask_a, match_a, to);
        end
    endtask

    task automatic test_start_held();
        int cyc;
        bit to;
        bit extra;
        mode = 2'd0;
        launch_a(1'b1, cyc, to);
        checks++;
        if (to || cyc != 33 || mask_a !== 16'hA655) begin
            errors++;
            $display("FAIL held_scan: got cycles=%0d mask=%h timeout=%0b, want 33 and a655", cyc, mask_a, to);
        end
        extra = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (busy_a || done_a) extra = 1'b1;
        end
        checks++;
        if (extra) begin
            errors++;
            $display("FAIL held_single: got a second scan after release, want exactly one");
        end
    endtask

    task automatic test_back_to_back();
        int cyc1, cyc2;
        bit to1, to2;
        mode = 2'd0;
        launch_a(1'b0, cyc1, to1);
        launch_a(1'b0, cyc2, to2);
        checks++;
        if (to1 || to2 || cyc2 != 33) begin
            errors++;
            $display("FAIL back_to_back: got second DONE after %0d (timeouts %0b/%0b), want 33", cyc2, to1, to2);
        end
        checks++;
        if (mask_a !== 16'hA655 || count_a !== 5'd8 || match_a !== 1'b1) begin
            errors++;
            $display("FAIL back_to_back_result: got mask=%h count=%0d match=%b, want a655/8/1",
                     mask_a, count_a, match_a);
        end
    endtask

    task automatic test_settle_zero();
        int cyc;
        bit to;
        bit bad_step;
        logic [3:0] bad_probe;
        mode = 2'd0;
        bad_step = 1'b0;
        bad_probe = 4'd0;
        @(negedge clk);
        start_b = 1'b1;
        cyc = 0;
        to = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            start_b = 1'b0;
            cyc++;
            if (cyc <= 16 && probe_b !== 4'(cyc - 1)) begin
                bad_step = 1'b1;
                bad_probe = probe_b;
            end
            if (done_b) begin
                to = 1'b0;
                break;
            end
        end
        $display("scan b: cycles=%0d mask=%h count=%0d match=%0b", cyc, mask_b, count_b, match_b);
        checks++;
        if (to || cyc != 17) begin
            errors++;
            $display("FAIL settle0_latency: got %0d (timeout=%0b), want 17", cyc, to);
        end
        checks++;
        if (bad_step) begin
            errors++;
            $display("FAIL settle0_probe_step: got probe=%h off sequence, want one step per cycle", bad_probe);
        end
        checks++;
        if (mask_b !== 16'hA655 || count_b !== 5'd8 || match_b !== 1'b1) begin
            errors++;
            $display("FAIL settle0_result: got mask=%h count=%0d match=%b, want a655/8/1",
                     mask_b, count_b, match_b);
        end
    endtask

    initial begin
        test_reset();
        test_scan("default", 2'd0, 16'hA655, 5'd8, 1'b1);
        test_scan("tied_low", 2'd1, 16'h0000, 5'd0, 1'b0);
        test_scan("tied_high", 2'd2, 16'hFFFF, 5'd16, 1'b0);
        test_scan("one_error", 2'd3, 16'h8655, 5'd7, 1'b0);
        test_mid_scan_reset();
        test_start_held();
        test_back_to_back();
        test_settle_zero();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
